// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue FSM states, data width and the
// baud-generator constants used by the serializer and by test benches.
package uart_pkg;

  typedef enum logic [1:0] {
    TXF_IDLE   = 2'd0,
    TXF_ACCEPT = 2'd1,
    TXF_DONE   = 2'd2
  } tx_fifo_state_t;

  localparam int UART_DATA_W = 8;

  // Baud generation: a phase accumulator of UART_ACC_W bits advanced by
  // UART_ACC_INC each clock overflows at the bit rate.
  localparam longint unsigned UART_CLK_HZ = 64'd100_000_000;
  localparam longint unsigned UART_BAUD   = 64'd115_200;
  localparam longint unsigned UART_ACC_W  = 64'd16;

  // Rounded accumulator increment: baud * 2^acc_w / clk_hz.
  function automatic longint unsigned baud_acc_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned acc_w
  );
    longint unsigned num;
    num = (baud << acc_w) + (clk_hz >> 1);
    return num / clk_hz;
  endfunction

  localparam longint unsigned UART_ACC_INC =
    baud_acc_inc(UART_CLK_HZ, UART_BAUD, UART_ACC_W);

endpackage

// File: rtl/sync_fifo_mem.sv
// Synchronous FIFO storage: array with a registered read port, wrap-bit
// read/write pointers, and full/empty/level derived from the pointers.
module sync_fifo_mem #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             wr_fire;
  logic             rd_fire;

  // Same index with different wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // Writes into a full queue and reads from an empty one are ignored here,
  // so callers cannot corrupt the pointers.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = rd_data_reg;

  // Storage write; left without reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
    end
  end

  // Registered read of the head entry; the value holds until the next pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_fire) begin
      rd_data_reg <= mem[rd_ptr_reg[PTR_W-1:0]];
    end
  end

  // Pointer advance; a simultaneous write and read leaves the level unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmit serializer. Bytes arrive on a
// valid/ready port, are buffered in sync_fifo_mem, and are issued one frame
// at a time with a single-cycle tx_start, waiting on tx_busy between frames.
// Optional sticky overflow flag (with overflow_clear input) is built when
// UART_TX_FIFO_OVERFLOW_EN is defined; otherwise full-queue writes are
// silently dropped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = UART_DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic [PTR_W:0]   level,
  output logic             empty
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic             overflow,
  input  logic             overflow_clear
`endif
);

  tx_fifo_state_t state_reg;
  logic           tx_start_reg;
  logic           full;
  logic           pop;

  // Issue only from IDLE, with data queued and the serializer quiet. After a
  // reset the FSM is in IDLE, so a frame still on the wire blocks the next
  // issue through tx_busy without being disturbed.
  assign pop = (state_reg == TXF_IDLE) && !empty && !tx_busy;

  assign wr_ready = !full;
  assign tx_start = tx_start_reg;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (tx_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Issue FSM: pulse tx_start with the popped byte, wait for the serializer
  // to go busy, then wait for it to finish before looking at the queue again.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= TXF_IDLE;
      tx_start_reg <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      case (state_reg)
        TXF_IDLE: begin
          if (pop) begin
            tx_start_reg <= 1'b1;
            state_reg    <= TXF_ACCEPT;
          end
        end
        TXF_ACCEPT: begin
          if (tx_busy) begin
            state_reg <= TXF_DONE;
          end
        end
        TXF_DONE: begin
          if (!tx_busy) begin
            state_reg <= TXF_IDLE;
          end
        end
        default: begin
          state_reg <= TXF_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_reg;

  assign overflow = overflow_reg;

  // Sticky overflow: a rejected write sets it, and wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (wr_valid && full) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clear) begin
      overflow_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed steps plus a randomized
// phase, checked against a queue-based reference and a serializer model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       overflow;
  logic       overflow_clear = 1'b0;
  logic       ovf_exp;
`endif

  // Serializer model state and the reference queues
  logic       ser_busy = 1'b0;
  logic       ext_busy = 1'b0;
  int         ser_cnt = 0;
  int         frame_len = 4;
  logic [7:0] held_data = 8'h00;
  logic       hold_chk = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int n_checks = 0;
  int n_pass = 0;

  assign tx_busy = ser_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clock    (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .level    (level),
    .empty    (empty)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Serializer: captures the byte on tx_start, stays busy frame_len cycles,
  // and expects tx_data to hold while the frame is on the wire.
  always begin
    @(posedge clk);
    #1;
    if (reset === 1'b1) hold_chk = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) ser_busy = 1'b0;
    end
    if (tx_start === 1'b1) begin
      check("tx_start_one_cycle", 32'(prev_start), 32'd0);
      got_q.push_back(tx_data);
      held_data = tx_data;
      hold_chk  = 1'b1;
      ser_busy  = 1'b1;
      ser_cnt   = frame_len;
    end else if (ser_busy && hold_chk) begin
      check("tx_data_hold", 32'(tx_data), 32'(held_data));
    end
    prev_start = tx_start;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(empty === 1'b1 && tx_busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("rst_overflow", 32'(overflow), 32'd0);
`endif

    // Single byte: tx_start one cycle after the accepting edge
    frame_len = 4;
    write_byte(8'hA5);
    check("a5_level_after_write", 32'(level), 32'd1);
    check("a5_no_start_yet", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("a5_tx_start", 32'(tx_start), 32'd1);
    check("a5_tx_data", 32'(tx_data), 32'hA5);
    check("a5_level_zero", 32'(level), 32'd0);
    drain(100);
    compare_queues("a5_order");

    // Burst to full while the serializer is held busy, then overflow
    frame_len = 3;
    ext_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_no_start", 32'(tx_start), 32'd0);
    wr_data = 8'hFF;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("drop_level", 32'(level), 32'(DEPTH));
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("ovf_set", 32'(overflow), 32'd1);
    repeat (4) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 32'd1);
    wr_valid = 1'b1;
    overflow_clear = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("ovf_set_beats_clear", 32'(overflow), 32'd1);
    @(negedge clk);
    overflow_clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
`endif
    ext_busy = 1'b0;
    @(negedge clk);
    check("pop_from_full_level", 32'(level), 32'(DEPTH - 1));
    check("pop_from_full_wr_ready", 32'(wr_ready), 32'd1);
    check("pop_from_full_start", 32'(tx_start), 32'd1);
    check("pop_from_full_data", 32'(tx_data), 32'h00);
    drain(1000);
    compare_queues("burst_order");

    // Serializer busy from outside: queue holds, then issues within a cycle
    ext_busy = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      check("hold_no_start", 32'(tx_start), 32'd0);
      @(negedge clk);
    end
    check("hold_level", 32'(level), 32'd3);
    ext_busy = 1'b0;
    @(negedge clk);
    check("release_start", 32'(tx_start), 32'd1);
    check("release_data", 32'(tx_data), 32'(exp_q[0]));
    drain(500);
    compare_queues("hold_order");

    // Randomized traffic against the queue model, incl. wraps and full pops
    frame_len = 3;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ovf_exp = 1'b0;
`endif
    for (int c = 0; c < 600; c++) begin
      int occ;
      int prob;
      occ  = exp_q.size() - got_q.size();
      prob = (c < 300) ? 85 : 25;
      check("rnd_level", 32'(level), 32'(occ));
      check("rnd_wr_ready", 32'(wr_ready), 32'(occ < DEPTH));
      check("rnd_empty", 32'(empty), 32'(occ == 0));
`ifdef UART_TX_FIFO_OVERFLOW_EN
      check("rnd_overflow", 32'(overflow), 32'(ovf_exp));
      overflow_clear = ($urandom_range(0, 15) == 0);
`endif
      wr_valid = ($urandom_range(0, 99) < prob);
      wr_data  = 8'($urandom);
      if (wr_valid && occ < DEPTH) exp_q.push_back(wr_data);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      if (wr_valid && occ >= DEPTH) ovf_exp = 1'b1;
      else if (overflow_clear) ovf_exp = 1'b0;
`endif
      @(negedge clk);
    end
    wr_valid = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    overflow_clear = 1'b0;
`endif
    drain(2000);
    compare_queues("rnd_order");

    // Reset while DONE with five bytes queued; in-flight frame keeps running
    frame_len = 20;
    for (int i = 0; i < 6; i++) write_byte(8'h40 + 8'(i));
    repeat (2) @(negedge clk);
    check("mid_level_before_reset", 32'(level), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_busy_kept", 32'(tx_busy), 32'd1);
    write_byte(8'h3C);
    for (int n = 0; n < 50 && tx_busy === 1'b1; n++) begin
      check("mid_rst_no_issue", 32'(tx_start), 32'd0);
      @(negedge clk);
    end
    check("mid_rst_busy_fell", 32'(tx_busy), 32'd0);
    @(negedge clk);
    check("mid_rst_issue", 32'(tx_start), 32'd1);
    check("mid_rst_issue_data", 32'(tx_data), 32'h3C);
    frame_len = 2;
    drain(500);
    compare_queues("mid_rst_order");

    // Pointers now at 1/1: fill to index 15, then write and pop on the wrap
    ext_busy = 1'b1;
    for (int i = 0; i < 14; i++) write_byte(8'($urandom));
    check("wrap_level_pre", 32'(level), 32'd14);
    ext_busy = 1'b0;
    write_byte(8'hE7);
    check("wrap_level_same", 32'(level), 32'd14);
    check("wrap_start", 32'(tx_start), 32'd1);
    check("wrap_head", 32'(tx_data), 32'(exp_q[0]));
    write_byte(8'h7E);
    drain(1000);
    compare_queues("wrap_order");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
